// File: rtl/ps2_pkg.sv
// Shared constants, scan codes and FSM state types for the PS/2 direction decoder.
package ps2_pkg;

  localparam logic [1:0] DIR_NONE = 2'b00;
  localparam logic [1:0] DIR_NEG  = 2'b10;
  localparam logic [1:0] DIR_POS  = 2'b01;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_W     = 8'h1D;
  localparam logic [7:0] SC_S     = 8'h1B;
  localparam logic [7:0] SC_A     = 8'h1C;
  localparam logic [7:0] SC_D     = 8'h23;

  typedef enum logic [1:0] {FR_IDLE, FR_DATA, FR_PARITY, FR_STOP} frame_state_t;
  typedef enum logic [1:0] {CS_BASE, CS_EXT, CS_BRK, CS_EXT_BRK} code_state_t;

  // Opposing keys held together cancel to none, so 11 is never produced.
  function automatic logic [1:0] dir_pair(input logic neg, input logic pos);
    if (neg && !pos)      return DIR_NEG;
    else if (pos && !neg) return DIR_POS;
    else                  return DIR_NONE;
  endfunction

endpackage

// File: rtl/ps2_rx_frame.sv
// PS/2 receiver: input synchronisers, falling-edge detect, 11-bit frame FSM and
// inactivity timeout. Emits one-cycle byte_valid / frame_err pulses.
module ps2_rx_frame
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [SYNC_STAGES-1:0] clk_sync, data_sync;
  logic                   clk_prev;
  logic                   fall, bit_in;

  frame_state_t state, state_n;
  logic [2:0]   bit_cnt, bit_cnt_n;
  logic [7:0]   shift, shift_n;
  logic         parity_bit, parity_bit_n;
  logic [TW-1:0] tcount, tcount_n;
  logic         valid_n, err_n;
  logic [7:0]   data_n;

  // Synchronisers reset to the idle-high line level so reset never fakes an edge.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      clk_sync  <= '1;
      data_sync <= '1;
      clk_prev  <= 1'b1;
    end else begin
      clk_sync  <= {clk_sync[SYNC_STAGES-2:0], ps2_clk};
      data_sync <= {data_sync[SYNC_STAGES-2:0], ps2_data};
      clk_prev  <= clk_sync[SYNC_STAGES-1];
    end
  end

  assign fall   = clk_prev & ~clk_sync[SYNC_STAGES-1];
  assign bit_in = data_sync[SYNC_STAGES-1];

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state      <= FR_IDLE;
      bit_cnt    <= '0;
      shift      <= '0;
      parity_bit <= 1'b0;
      tcount     <= '0;
      byte_valid <= 1'b0;
      byte_data  <= '0;
      frame_err  <= 1'b0;
    end else begin
      state      <= state_n;
      bit_cnt    <= bit_cnt_n;
      shift      <= shift_n;
      parity_bit <= parity_bit_n;
      tcount     <= tcount_n;
      byte_valid <= valid_n;
      byte_data  <= data_n;
      frame_err  <= err_n;
    end
  end

  always_comb begin
    state_n      = state;
    bit_cnt_n    = bit_cnt;
    shift_n      = shift;
    parity_bit_n = parity_bit;
    tcount_n     = '0;
    valid_n      = 1'b0;
    err_n        = 1'b0;
    data_n       = byte_data;
    if (fall) begin
      case (state)
        FR_IDLE: begin
          if (!bit_in) begin
            state_n   = FR_DATA;
            bit_cnt_n = '0;
          end
        end
        FR_DATA: begin
          shift_n   = {bit_in, shift[7:1]};
          bit_cnt_n = bit_cnt + 3'd1;
          if (bit_cnt == 3'd7) state_n = FR_PARITY;
        end
        FR_PARITY: begin
          parity_bit_n = bit_in;
          state_n      = FR_STOP;
        end
        FR_STOP: begin
          state_n = FR_IDLE;
          if ((^shift ^ parity_bit) && bit_in) begin
            valid_n = 1'b1;
            data_n  = shift;
          end else begin
            err_n = 1'b1;
          end
        end
        default: state_n = FR_IDLE;
      endcase
    end else if (state != FR_IDLE) begin
      if (tcount == TW'(TIMEOUT_CYCLES - 1)) begin
        state_n = FR_IDLE;
        err_n   = 1'b1;
      end else begin
        tcount_n = tcount + TW'(1);
      end
    end
  end

endmodule

// File: rtl/ps2_direction_decoder.sv
// Arrow-key make/break tracker driving the 4-bit sprite direction bus.
// Define PS2_WASD_EN to also track W/S/A/D as aliases of the arrows.
module ps2_direction_decoder
  import ps2_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 50000,
  parameter int SYNC_STAGES    = 2
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [3:0] directions,
  output logic       byte_valid,
  output logic [7:0] byte_data,
  output logic       frame_err
);

  code_state_t cs, cs_n;
  logic up, down, left, right;
  logic up_n, down_n, left_n, right_n;
  logic eff_up, eff_down, eff_left, eff_right;

  ps2_rx_frame #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_rx (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

`ifdef PS2_WASD_EN
  logic w, s, a, d;
  logic w_n, s_n, a_n, d_n;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      w <= 1'b0; s <= 1'b0; a <= 1'b0; d <= 1'b0;
    end else begin
      w <= w_n; s <= s_n; a <= a_n; d <= d_n;
    end
  end

  assign eff_up    = up | w;
  assign eff_down  = down | s;
  assign eff_left  = left | a;
  assign eff_right = right | d;
`else
  assign eff_up    = up;
  assign eff_down  = down;
  assign eff_left  = left;
  assign eff_right = right;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      cs         <= CS_BASE;
      up         <= 1'b0;
      down       <= 1'b0;
      left       <= 1'b0;
      right      <= 1'b0;
      directions <= '0;
    end else begin
      cs         <= cs_n;
      up         <= up_n;
      down       <= down_n;
      left       <= left_n;
      right      <= right_n;
      directions <= {dir_pair(eff_up, eff_down), dir_pair(eff_left, eff_right)};
    end
  end

  always_comb begin
    cs_n    = cs;
    up_n    = up;
    down_n  = down;
    left_n  = left;
    right_n = right;
`ifdef PS2_WASD_EN
    w_n = w; s_n = s; a_n = a; d_n = d;
`endif
    // A broken frame leaves the prefix sequence unknowable, but held keys stay held.
    if (frame_err) begin
      cs_n = CS_BASE;
    end else if (byte_valid) begin
      case (cs)
        CS_BASE: begin
          case (byte_data)
            SC_EXT: cs_n = CS_EXT;
            SC_BRK: cs_n = CS_BRK;
`ifdef PS2_WASD_EN
            SC_W:   w_n = 1'b1;
            SC_S:   s_n = 1'b1;
            SC_A:   a_n = 1'b1;
            SC_D:   d_n = 1'b1;
`endif
            default: ;
          endcase
        end
        CS_EXT: begin
          cs_n = CS_BASE;
          case (byte_data)
            SC_BRK:   cs_n    = CS_EXT_BRK;
            SC_UP:    up_n    = 1'b1;
            SC_DOWN:  down_n  = 1'b1;
            SC_LEFT:  left_n  = 1'b1;
            SC_RIGHT: right_n = 1'b1;
            default: ;
          endcase
        end
        CS_BRK: begin
          cs_n = CS_BASE;
`ifdef PS2_WASD_EN
          case (byte_data)
            SC_W: w_n = 1'b0;
            SC_S: s_n = 1'b0;
            SC_A: a_n = 1'b0;
            SC_D: d_n = 1'b0;
            default: ;
          endcase
`endif
        end
        CS_EXT_BRK: begin
          cs_n = CS_BASE;
          case (byte_data)
            SC_UP:    up_n    = 1'b0;
            SC_DOWN:  down_n  = 1'b0;
            SC_LEFT:  left_n  = 1'b0;
            SC_RIGHT: right_n = 1'b0;
            default: ;
          endcase
        end
        default: cs_n = CS_BASE;
      endcase
    end
  end

endmodule

// File: tb/tb_ps2_direction_decoder.sv
// Directed bench for ps2_direction_decoder; PS2_WASD_EN selects the expected WASD result.
module tb_ps2_direction_decoder;

  localparam int TIMEOUT = 100;
  localparam int SYNC    = 2;
  localparam int LAT     = SYNC + 3;
  localparam int HALF    = 10;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ps2_clk = 1'b1;
  logic       ps2_data = 1'b1;
  logic [3:0] directions;
  logic       byte_valid;
  logic [7:0] byte_data;
  logic       frame_err;

  int checks = 0;
  int errors = 0;
  int bv_cnt = 0;
  int fe_cnt = 0;
  int bv0, fe0;
  logic [3:0] dir_before, dir_after;

  ps2_direction_decoder #(
    .TIMEOUT_CYCLES(TIMEOUT),
    .SYNC_STAGES   (SYNC)
  ) dut (
    .clk       (clk),
    .resetn    (resetn),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .directions(directions),
    .byte_valid(byte_valid),
    .byte_data (byte_data),
    .frame_err (frame_err)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #3_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  // pulse monitor
  always @(negedge clk) begin
    if (byte_valid === 1'b1) bv_cnt++;
    if (frame_err === 1'b1) fe_cnt++;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // driver tasks; directions is sampled LAT-1 and LAT cycles after every falling edge
  task automatic send_bit(input logic b);
    @(negedge clk);
    ps2_data = b;
    repeat (HALF) @(negedge clk);
    ps2_clk = 1'b0;
    repeat (LAT - 1) @(negedge clk);
    dir_before = directions;
    @(negedge clk);
    dir_after = directions;
    repeat (HALF - LAT) @(negedge clk);
    ps2_clk = 1'b1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic flip_parity);
    send_bit(1'b0);
    for (int i = 0; i < 8; i++) send_bit(b[i]);
    send_bit((~^b) ^ flip_parity);
    send_bit(1'b1);
    repeat (HALF) @(negedge clk);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check("reset_directions", 8'(directions), 8'h0);
    check("reset_byte_valid", 8'(byte_valid), 8'h0);
    check("reset_byte_data", byte_data, 8'h00);
    check("reset_frame_err", 8'(frame_err), 8'h0);
    resetn = 1'b1;
    repeat (5) @(negedge clk);

    // idle edge with data high is not a start bit
    bv0 = bv_cnt; fe0 = fe_cnt;
    send_bit(1'b1);
    repeat (HALF) @(negedge clk);
    check("idle_edge_no_err", 8'(fe_cnt - fe0), 8'd0);
    check("idle_edge_no_byte", 8'(bv_cnt - bv0), 8'd0);

    bv0 = bv_cnt;
    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    check("up_byte_valid_count", 8'(bv_cnt - bv0), 8'd2);
    check("up_latency_before", 8'(dir_before), 8'h0);
    check("up_latency_after", 8'(dir_after), 8'h8);
    check("up_byte_data", byte_data, 8'h75);

    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    check("up_typematic", 8'(directions), 8'h8);

    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    check("up_release", 8'(directions), 8'h0);

    send_byte(8'hE0, 1'b0);
    send_byte(8'h75, 1'b0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h72, 1'b0);
    check("up_down_cancel", 8'(directions), 8'h0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h75, 1'b0);
    check("down_after_up_release", 8'(directions), 8'h4);

    bv0 = bv_cnt; fe0 = fe_cnt;
    send_byte(8'h6B, 1'b1);
    check("parity_err_pulse", 8'(fe_cnt - fe0), 8'd1);
    check("parity_err_no_byte", 8'(bv_cnt - bv0), 8'd0);
    check("parity_err_dir", 8'(directions), 8'h4);
    check("parity_err_byte_held", byte_data, 8'h75);

    send_byte(8'hE0, 1'b0);
    send_byte(8'h6B, 1'b0);
    check("left_make", 8'(directions), 8'h6);
    check("left_byte_data", byte_data, 8'h6B);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h6B, 1'b0);
    check("left_release", 8'(directions), 8'h4);

    // partial frame then silence
    fe0 = fe_cnt; bv0 = bv_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    repeat (2 * TIMEOUT + 20) @(negedge clk);
    check("timeout_err_once", 8'(fe_cnt - fe0), 8'd1);
    check("timeout_no_byte", 8'(bv_cnt - bv0), 8'd0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h74, 1'b0);
    check("right_after_timeout", 8'(directions), 8'h5);

    // reset in the middle of a frame
    bv0 = bv_cnt;
    send_bit(1'b0);
    send_bit(1'b1);
    send_bit(1'b0);
    @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("midreset_directions", 8'(directions), 8'h0);
    check("midreset_byte_valid", 8'(byte_valid), 8'h0);
    resetn = 1'b1;
    repeat (50) @(negedge clk);
    check("midreset_no_byte", 8'(bv_cnt - bv0), 8'd0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h72, 1'b0);
    check("down_after_reset", 8'(directions), 8'h4);
    send_byte(8'hE0, 1'b0);
    send_byte(8'hF0, 1'b0);
    send_byte(8'h72, 1'b0);
    check("down_release", 8'(directions), 8'h0);

    send_byte(8'h1D, 1'b0);
`ifdef PS2_WASD_EN
    check("w_make", 8'(directions), 8'h8);
`else
    check("w_ignored", 8'(directions), 8'h0);
`endif
    send_byte(8'hF0, 1'b0);
    send_byte(8'h1D, 1'b0);
    check("w_release", 8'(directions), 8'h0);
    send_byte(8'hE0, 1'b0);
    send_byte(8'h74, 1'b0);
    check("right_after_w", 8'(directions), 8'h1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
